// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon game button path and game FSM.
// Holds the channel count, the debounce default and the button-index width.
package simon_pkg;

    localparam int N_BTNS                 = 4;
    localparam int DEBOUNCE_TICKS_DEFAULT = 250000;
    localparam int BTN_IDX_W              = 2;

    typedef logic [BTN_IDX_W-1:0] btn_idx_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_ONE,
        FIFO_TWO
    } fifo_state_t;

    // Lowest set index wins; returns 0 for an all-zero vector.
    function automatic btn_idx_t first_set(input logic [N_BTNS-1:0] v);
        btn_idx_t r;
        r = '0;
        for (int i = N_BTNS - 1; i >= 0; i--) begin
            if (v[i]) r = BTN_IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stability counter, debounced level
// register and a one-cycle press strobe issued together with the 0->1 level update.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = simon_pkg::DEBOUNCE_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The counter never passes LAST: it clears on match or on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                press <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_event_encoder.sv
// Debounces four buttons, priority-encodes press strobes and queues them in a
// 2-entry event buffer with valid/ack handshake and a sticky overflow flag.
module btn_event_encoder
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT,
    parameter int NUM_BTNS       = N_BTNS
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_BTNS-1:0] BTN,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic                ev_valid,
    output btn_idx_t            ev_code,
    input  logic                ev_ack,
    output logic                ev_overflow
);

    logic [NUM_BTNS-1:0] press;
    logic                strobe;
    btn_idx_t            code;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_db (
            .clk  (CLK),
            .rst  (RST),
            .btn  (BTN[g]),
            .level(btn_level[g]),
            .press(press[g])
        );
    end

    assign strobe = |press;
    assign code   = first_set(press);

    fifo_state_t state, state_nxt;
    btn_idx_t    head, head_nxt;
    btn_idx_t    tail, tail_nxt;
    logic        ovf_nxt;

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        ovf_nxt   = ev_overflow;
        case (state)
            FIFO_EMPTY: begin
                if (strobe) begin
                    state_nxt = FIFO_ONE;
                    head_nxt  = code;
                end
            end
            FIFO_ONE: begin
                if (strobe && !ev_ack) begin
                    state_nxt = FIFO_TWO;
                    tail_nxt  = code;
                end else if (!strobe && ev_ack) begin
                    state_nxt = FIFO_EMPTY;
                end else if (strobe && ev_ack) begin
                    head_nxt = code;
                end
            end
            FIFO_TWO: begin
                if (ev_ack) begin
                    head_nxt = tail;
                    if (strobe) tail_nxt = code;
                    else        state_nxt = FIFO_ONE;
                end else if (strobe) begin
                    ovf_nxt = 1'b1;
                end
            end
            default: state_nxt = FIFO_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= FIFO_EMPTY;
            head        <= '0;
            tail        <= '0;
            ev_overflow <= 1'b0;
        end else begin
            state       <= state_nxt;
            head        <= head_nxt;
            tail        <= tail_nxt;
            ev_overflow <= ovf_nxt;
        end
    end

    assign ev_valid = (state != FIFO_EMPTY);
    assign ev_code  = head;

endmodule

// File: tb/tb_btn_event_encoder.sv
// Randomized plus directed bench for btn_event_encoder with a behavioural model
// and an event scoreboard checked by an independent monitor.
module tb_btn_event_encoder;

    localparam int T = 4;

    logic       CLK;
    logic       RST;
    logic [3:0] BTN;
    logic [3:0] btn_level;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       ev_ack;
    logic       ev_overflow;

    btn_event_encoder #(.DEBOUNCE_TICKS(T), .NUM_BTNS(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .BTN        (BTN),
        .btn_level  (btn_level),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .ev_ack     (ev_ack),
        .ev_overflow(ev_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: a level flips once its synchronized input has disagreed
    // for T consecutive cycles; accepted presses live in a queue of at most two.
    int m_s1 [4];
    int m_s2 [4];
    int m_lvl[4];
    int m_age[4];
    int m_pend = -1;
    int m_q[$];
    int m_ovf = 0;
    int exp_q[$];

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_age[i] = 0;
            end
            m_pend = -1;
            m_q.delete();
            exp_q.delete();
            m_ovf = 0;
        end else begin
            if (ev_ack && m_q.size() > 0) void'(m_q.pop_front());
            if (m_pend >= 0) begin
                if (m_q.size() < 2) begin
                    m_q.push_back(m_pend);
                    exp_q.push_back(m_pend);
                end else begin
                    m_ovf = 1;
                end
            end
            m_pend = -1;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_age[i]++;
                    if (m_age[i] == T) begin
                        m_lvl[i] = m_s2[i];
                        m_age[i] = 0;
                        if (m_lvl[i] == 1 && m_pend < 0) m_pend = i;
                    end
                end else begin
                    m_age[i] = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                m_s2[i] = m_s1[i];
                m_s1[i] = int'(BTN[i]);
            end
        end
    end

    // Monitor: per-cycle state comparison and handshake-driven scoreboard pops.
    initial begin
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            begin
                int lv;
                lv = 0;
                for (int i = 0; i < 4; i++) lv = lv | (m_lvl[i] << i);
                chk("btn_level", int'(btn_level), lv);
            end
            chk("ev_valid", int'(ev_valid), (m_q.size() > 0) ? 1 : 0);
            chk("ev_overflow", int'(ev_overflow), m_ovf);
            if (m_q.size() > 0) chk("ev_code_head", int'(ev_code), m_q[0]);
            if (ev_valid && ev_ack && !RST) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", int'(ev_code), -1);
                end else begin
                    chk("event_code", int'(ev_code), exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    int hold[4];

    initial begin
        RST = 1'b1; BTN = 4'h0; ev_ack = 1'b0;
        cyc(3);
        chk("reset_valid", int'(ev_valid), 0);
        chk("reset_level", int'(btn_level), 0);
        chk("reset_ovf", int'(ev_overflow), 0);
        RST = 1'b0;
        cyc(2);

        // Clean press on BTN[2]
        BTN = 4'b0100;
        cyc(5);
        chk("b2_level_c5", int'(btn_level[2]), 0);
        cyc(1);
        chk("b2_level_c6", int'(btn_level[2]), 1);
        chk("b2_valid_c6", int'(ev_valid), 0);
        cyc(1);
        chk("b2_valid_c7", int'(ev_valid), 1);
        chk("b2_code_c7", int'(ev_code), 2);
        ev_ack = 1'b1;
        cyc(1);
        ev_ack = 1'b0;
        chk("b2_valid_after_ack", int'(ev_valid), 0);
        BTN = 4'h0;
        cyc(12);

        // Glitch shorter than the debounce window
        BTN = 4'b0010;
        cyc(3);
        BTN = 4'h0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                cyc(1);
                if (btn_level != 4'h0 || ev_valid) seen = 1;
            end
            chk("glitch_ignored", seen, 0);
        end

        // Simultaneous BTN[3] and BTN[0]
        BTN = 4'b1001;
        cyc(8);
        chk("simul_valid", int'(ev_valid), 1);
        chk("simul_code", int'(ev_code), 0);
        chk("simul_ovf", int'(ev_overflow), 0);
        ev_ack = 1'b1;
        cyc(1);
        ev_ack = 1'b0;
        chk("simul_single", int'(ev_valid), 0);
        BTN = 4'h0;
        cyc(12);

        // Three spaced presses with no ack overflow the buffer
        BTN = 4'b0001; cyc(8); BTN = 4'h0; cyc(2);
        BTN = 4'b0010; cyc(8); BTN = 4'h0; cyc(2);
        BTN = 4'b1000; cyc(8); BTN = 4'h0; cyc(2);
        chk("ovf_set", int'(ev_overflow), 1);
        chk("ovf_head0", int'(ev_code), 0);
        ev_ack = 1'b1;
        cyc(1);
        chk("ovf_head1", int'(ev_code), 1);
        chk("ovf_valid1", int'(ev_valid), 1);
        cyc(1);
        ev_ack = 1'b0;
        chk("ovf_drained", int'(ev_valid), 0);
        chk("ovf_sticky", int'(ev_overflow), 1);
        cyc(12);

        // Reset while an event is pending and the button stays held
        BTN = 4'b0010;
        begin
            int n;
            n = 0;
            while (!ev_valid && n < 20) begin
                cyc(1);
                n++;
            end
            chk("rst_pending_valid", int'(ev_valid), 1);
        end
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_ovf", int'(ev_overflow), 0);
        chk("rst_level", int'(btn_level), 0);
        cyc(6);
        chk("rst_relevel", int'(btn_level[1]), 1);
        cyc(1);
        chk("rst_reevent", int'(ev_valid), 1);
        chk("rst_recode", int'(ev_code), 1);
        ev_ack = 1'b1;
        cyc(1);
        ev_ack = 1'b0;
        BTN = 4'h0;
        cyc(12);

        // Long hold with ack always high
        BTN = 4'b1000;
        ev_ack = 1'b1;
        begin
            int pulses, prev;
            pulses = 0; prev = 0;
            for (int k = 0; k < 1000; k++) begin
                cyc(1);
                if (ev_valid && prev == 0) pulses++;
                prev = int'(ev_valid);
            end
            chk("hold_one_pulse", pulses, 1);
        end
        BTN = 4'h0;
        cyc(12);
        ev_ack = 1'b0;

        // Random traffic
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    BTN[i] = ($urandom_range(0, 2) == 0);
                    hold[i] = int'($urandom_range(1, 12));
                end else begin
                    hold[i]--;
                end
            end
            ev_ack = ($urandom_range(0, 2) == 0);
            RST = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        RST = 1'b0;
        BTN = 4'h0;
        ev_ack = 1'b1;
        cyc(30);
        chk("final_scoreboard_empty", exp_q.size(), 0);
        chk("final_valid", int'(ev_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
